rr_grant_arbiter: RTL and testbench

- 4-requester round-robin arbiter with hold/release handshake and an optional hold timeout.
- Produces a registered one-hot grant vector. The vector feeds the 4-to-2 one-hot encoder stage directly downstream, which converts it to a binary requester index for shared-resource muxing (e.g. the memory/bus port).
- Guarantees grant_out is always 4'b0000 or exactly one-hot, so the encoder never sees an illegal pattern.

---
 rtl/rr_grant_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter with hold/release handshake and optional hold timeout.
// The grant vector is registered and always zero or one-hot, so it can feed a one-hot encoder directly.
module rr_grant_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] req_in,
    input  logic       done_in,
    output logic [3:0] grant_out,
    output logic       grant_valid_out,
    output logic       timeout_out
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Last hold count at which a timeout fires; unused when TIMEOUT is zero.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       pick;
    logic             rel_normal;
    logic             rel_timeout;

    // First requester at or after the priority pointer, circularly.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick        = rr_pick(req_in, ptr_q);
    assign rel_normal  = done_in || !req_in[owner_q];
    assign rel_timeout = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_d = 4'b0000;
                if (req_in != 4'b0000) begin
                    owner_d = pick;
                    grant_d = 4'b0001 << pick;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (rel_normal || rel_timeout) begin
                    // A normal release takes precedence, so a coincident done/drop never reports a timeout.
                    timeout_d = rel_timeout && !rel_normal;
                    grant_d   = 4'b0000;
                    ptr_d     = owner_q + 2'd1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = S_IDLE;
            end
        endcase

        grant_valid_d = (grant_d != 4'b0000);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= S_IDLE;
            ptr_q         <= 2'd0;
            owner_q       <= 2'd0;
            cnt_q         <= '0;
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_out       = grant_q;
    assign grant_valid_out = grant_valid_q;
    assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rr_grant_arbiter;

    localparam int TO = 16;

    logic       clk_in;
    logic       rst_in;
    logic [3:0] req_in;
    logic       done_in;
    logic [3:0] grant_out;
    logic       grant_valid_out;
    logic       timeout_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 = none), rotating priority, cycles the grant has been visible.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_held  = 0;
    logic [3:0] m_grant = 4'b0000;
    logic       m_to    = 1'b0;

    rr_grant_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_in         (req_in),
        .done_in        (done_in),
        .grant_out      (grant_out),
        .grant_valid_out(grant_valid_out),
        .timeout_out    (timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic void model_release();
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_held  = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic d, input logic rs);
        m_to = 1'b0;
        if (!rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else if (d || !r[m_owner]) begin
            model_release();
        end else if (TO != 0 && m_held == TO) begin
            model_release();
            m_to = 1'b1;
        end else begin
            m_held++;
        end
        m_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    task automatic tick();
        logic [3:0] r;
        logic       d;
        logic       rs;
        r  = req_in;
        d  = done_in;
        rs = rst_in;
        @(posedge clk_in);
        model_step(r, d, rs);
        #1;
    endtask

    task automatic test_reset();
        rst_in  = 1'b0;
        req_in  = 4'b1111;
        done_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({grant_out, grant_valid_out, timeout_out} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got grant=%b valid=%b to=%b, want all 0", grant_out, grant_valid_out, timeout_out);
            end
        end
        rst_in = 1'b1;
        tick();
        n_tests++;
        if (grant_out !== 4'b0001 || grant_valid_out !== 1'b1 || timeout_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got grant=%b valid=%b to=%b, want 0001/1/0", grant_out, grant_valid_out, timeout_out);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        req_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            done_in = (m_grant != 4'b0000);
            tick();
            n_tests++;
            if (grant_out !== exp_seq[i] || grant_out !== m_grant || grant_valid_out !== (exp_seq[i] != 4'b0000)) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got grant=%b valid=%b, want %b", i, grant_out, grant_valid_out, exp_seq[i]);
            end
        end
        done_in = 1'b0;
    endtask

    task automatic test_wrap();
        // Owner 0 holds; release it, grant owner 1, release it so priority sits at 2.
        done_in = 1'b1; req_in = 4'b0010; tick();
        done_in = 1'b0; tick();
        n_tests++;
        if (grant_out !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_setup: got grant=%b, want 0010", grant_out);
        end
        done_in = 1'b1; tick();
        done_in = 1'b0; req_in = 4'b0011; tick();
        n_tests++;
        if (grant_out !== 4'b0001 || grant_out !== m_grant) begin
            n_fail++;
            $display("FAIL wrap_grant0: got grant=%b, want 0001", grant_out);
        end
        done_in = 1'b1; tick();
        done_in = 1'b0; tick();
        n_tests++;
        if (grant_out !== 4'b0010 || grant_out !== m_grant) begin
            n_fail++;
            $display("FAIL wrap_grant1: got grant=%b, want 0010", grant_out);
        end
        done_in = 1'b1; tick();
        done_in = 1'b0; req_in = 4'b0000; tick();
    endtask

    task automatic test_timeout();
        int held;
        req_in  = 4'b0100;
        done_in = 1'b0;
        tick();
        held = 0;
        while (grant_out === 4'b0100 && held < 40) begin
            n_tests++;
            if (timeout_out !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early: got to=%b at held=%0d, want 0", timeout_out, held);
            end
            held++;
            tick();
        end
        n_tests++;
        if (held != TO || grant_out !== 4'b0000 || timeout_out !== 1'b1 || m_to !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: got held=%0d grant=%b to=%b, want %0d/0000/1", held, grant_out, timeout_out, TO);
        end
        tick();
        n_tests++;
        if (grant_out !== 4'b0100 || timeout_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regrant: got grant=%b to=%b, want 0100/0", grant_out, timeout_out);
        end
    endtask

    task automatic test_drop_and_coincide();
        done_in = 1'b1; tick();
        done_in = 1'b0; req_in = 4'b0001; tick();
        req_in = 4'b1110; tick();
        n_tests++;
        if (grant_out !== 4'b0000 || timeout_out !== 1'b0 || m_grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_release: got grant=%b to=%b, want 0000/0", grant_out, timeout_out);
        end
        tick();
        n_tests++;
        if (grant_out !== 4'b0010 || grant_out !== m_grant) begin
            n_fail++;
            $display("FAIL drop_next: got grant=%b, want 0010", grant_out);
        end
        for (int i = 0; i < TO - 1; i++) tick();
        n_tests++;
        if (grant_out !== 4'b0010) begin
            n_fail++;
            $display("FAIL coincide_hold: got grant=%b, want 0010", grant_out);
        end
        done_in = 1'b1; tick();
        n_tests++;
        if (grant_out !== 4'b0000 || timeout_out !== 1'b0 || m_to !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_done: got grant=%b to=%b, want 0000/0", grant_out, timeout_out);
        end
        done_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_in = 4'b1111;
        tick();
        n_tests++;
        if (grant_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_setup: got grant=%b, want 0100", grant_out);
        end
        for (int i = 0; i < 7; i++) tick();
        rst_in = 1'b0; tick();
        n_tests++;
        if (grant_out !== 4'b0000 || grant_valid_out !== 1'b0 || timeout_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got grant=%b valid=%b to=%b, want 0000/0/0", grant_out, grant_valid_out, timeout_out);
        end
        rst_in = 1'b1; req_in = 4'b1010; tick();
        n_tests++;
        if (grant_out !== 4'b0010 || grant_out !== m_grant) begin
            n_fail++;
            $display("FAIL mid_after: got grant=%b, want 0010", grant_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            req_in[0] = ($urandom_range(0, 9) < 8);
            req_in[1] = ($urandom_range(0, 9) < 6);
            req_in[2] = ($urandom_range(0, 9) < 8);
            req_in[3] = ($urandom_range(0, 9) < 4);
            done_in   = ($urandom_range(0, 15) == 0);
            rst_in    = ($urandom_range(0, 199) != 0);
            tick();
            n_tests++;
            if (grant_out !== m_grant || grant_valid_out !== (m_grant != 4'b0000) ||
                timeout_out !== m_to || $countones(grant_out) > 1) begin
                n_fail++;
                $display("FAIL random[%0d]: got grant=%b valid=%b to=%b, want %b/%b/%b",
                         i, grant_out, grant_valid_out, timeout_out, m_grant, (m_grant != 4'b0000), m_to);
            end
        end
    endtask

    initial begin
        rst_in  = 1'b0;
        req_in  = 4'b0000;
        done_in = 1'b0;
        #1;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_drop_and_coincide();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
